// File: rtl/fifo_gray_sync_param_pkg.sv
// ---------------------------------------------------------------------------
// fifo_gray_pkg
//   Shared types and helpers for the Gray-pointer FIFO family.
//   - rd_mode_e : read-port flavour (registered read or first-word-fall-through)
//   - bin2gray  : binary -> reflected Gray code
//   - gray2bin  : reflected Gray code -> binary
//   Helpers work on 32-bit values; callers cast to their pointer width.
// ---------------------------------------------------------------------------
package fifo_gray_pkg;

  typedef enum logic {
    RD_REG  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_sync_param_if.sv
// ---------------------------------------------------------------------------
// fifo_gray_sync_param_if
//   Producer/consumer handshake bundle of the parametrised Gray FIFO.
//   master : drives push/data_in/pop/err_clr, observes data and status
//   slave  : the FIFO itself
//   Status: data_out, data_valid, full, empty, almost_full, almost_empty,
//           level (0..DEPTH), sticky overflow/underflow.
// ---------------------------------------------------------------------------
interface fifo_gray_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, data_in, pop, err_clr,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, err_clr,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/fifo_gray_sync_param_ptr.sv
// ---------------------------------------------------------------------------
// fifo_gray_ptr
//   One FIFO pointer: AW+1-bit binary counter (extra wrap bit) with its Gray
//   image. Used once for the write side and once for the read side.
//   clk, rst : clock / async active-high reset
//   inc      : advance by one this edge
//   bin/gray : registered pointer
//   bin_nxt/gray_nxt : value the pointer takes at the coming edge
// ---------------------------------------------------------------------------
module fifo_gray_ptr
  import fifo_gray_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [AW:0] bin,
  output logic [AW:0] gray,
  output logic [AW:0] bin_nxt,
  output logic [AW:0] gray_nxt
);
  localparam int PW = AW + 1;

  // Next-state pointer; wraps naturally modulo 2*DEPTH.
  always_comb begin
    bin_nxt  = bin + {{AW{1'b0}}, inc};
    gray_nxt = PW'(bin2gray(32'(bin_nxt)));
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_nxt;
      gray <= gray_nxt;
    end
  end
endmodule

// File: rtl/fifo_gray_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_gray_sync_param
//   Single-clock FIFO with Gray-coded read/write pointers, selectable read
//   mode (FWFT=0 registered, FWFT=1 first-word-fall-through), programmable
//   almost-full/almost-empty thresholds, occupancy level and sticky
//   overflow/underflow errors (cleared by err_clr).
//   clk : clock, rst : async active-high reset
//   bus : fifo_gray_sync_param_if.slave (push/data_in/pop/err_clr in,
//         data and status out)
// ---------------------------------------------------------------------------
module fifo_gray_sync_param
  import fifo_gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = 14,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_gray_sync_param_if.slave  bus
);
  localparam int       AW        = $clog2(DEPTH);
  localparam rd_mode_e RD_MODE   = (FWFT != 0) ? RD_FWFT : RD_REG;
  localparam logic [AW:0] AFULL_LV  = AFULL_TH[AW:0];
  localparam logic [AW:0] AEMPTY_LV = AEMPTY_TH[AW:0];

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [AW:0] wbin_s, wgray_s, wbin_nxt_s, wgray_nxt_s;
  logic [AW:0] rbin_s, rgray_s, rbin_nxt_s, rgray_nxt_s;
  logic [AW:0] level_nxt_s;
  logic        push_ok_s, pop_ok_s;
  logic        full_r, empty_r, afull_r, aempty_r, ovf_r, udf_r;
  logic [AW:0] level_r;
  logic        unused_s;

  // Accepts use the flags as they stood before the edge.
  assign push_ok_s   = bus.push & ~full_r;
  assign pop_ok_s    = bus.pop & ~empty_r;
  assign level_nxt_s = wbin_nxt_s - rbin_nxt_s;

  fifo_gray_ptr #(.AW(AW)) u_wptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (push_ok_s),
    .bin      (wbin_s),
    .gray     (wgray_s),
    .bin_nxt  (wbin_nxt_s),
    .gray_nxt (wgray_nxt_s)
  );

  fifo_gray_ptr #(.AW(AW)) u_rptr (
    .clk      (clk),
    .rst      (rst),
    .inc      (pop_ok_s),
    .bin      (rbin_s),
    .gray     (rgray_s),
    .bin_nxt  (rbin_nxt_s),
    .gray_nxt (rgray_nxt_s)
  );

  // The registered Gray pointers and wrap bits are not consumed in the
  // single-clock build; they are what the dual-clock variant synchronises.
  assign unused_s = ^{wgray_s, rgray_s, wbin_s[AW], rbin_s[AW]};

  // Storage array; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wbin_s[AW-1:0]] <= bus.data_in;
    end
  end

  // Status flags registered from the next-state pointers.
  // Full: top two Gray bits inverted, the rest equal (one lap ahead).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      level_r  <= '0;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
    end else begin
      full_r   <= (wgray_nxt_s == {~rgray_nxt_s[AW:AW-1], rgray_nxt_s[AW-2:0]});
      empty_r  <= (wgray_nxt_s == rgray_nxt_s);
      level_r  <= level_nxt_s;
      afull_r  <= (level_nxt_s >= AFULL_LV);
      aempty_r <= (level_nxt_s <= AEMPTY_LV);
    end
  end

  // Sticky error flags; a clear outranks a new error in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else if (bus.err_clr) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r | (bus.push & full_r);
      udf_r <= udf_r | (bus.pop & empty_r);
    end
  end

  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.level        = level_r;
  assign bus.almost_full  = afull_r;
  assign bus.almost_empty = aempty_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = udf_r;

  generate
    if (RD_MODE == RD_REG) begin : g_rd_reg
      logic [DATA_WIDTH-1:0] dout_r;
      logic                  dv_r;

      // Registered read: data_out updates on an accepted pop, valid pulses once.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_r <= '0;
          dv_r   <= 1'b0;
        end else begin
          dv_r <= pop_ok_s;
          if (pop_ok_s) begin
            dout_r <= mem_r[rbin_s[AW-1:0]];
          end
        end
      end

      assign bus.data_out   = dout_r;
      assign bus.data_valid = dv_r;
    end else begin : g_rd_fwft
      // Head word is always presented; a pop just moves to the next one.
      assign bus.data_out   = mem_r[rbin_s[AW-1:0]];
      assign bus.data_valid = ~empty_r;
    end
  endgenerate
endmodule
